// File: rtl/alu_op_sequencer.sv
// Issue/capture stage in front of the combinational ALU: registers one operation per
// handshake, holds it for a full settle cycle, then captures and presents the result.
module alu_op_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [3:0]   op_sel,
  input  logic         op_cin,
  input  logic         op_use_acc,
  input  logic         op_use_carry,
  output logic [W-1:0] alu_A,
  output logic [W-1:0] alu_B,
  output logic [3:0]   alu_S,
  output logic         alu_C_in,
  input  logic [W-1:0] alu_D,
  input  logic         alu_C_out,
  input  logic         alu_z,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_d,
  output logic         res_cout,
  output logic         res_z,
  output logic [7:0]   op_count
);

  // state   | meaning
  // S_IDLE  | waiting for an operation, op_ready high
  // S_DRIVE | ALU inputs settling, result captured at end of cycle
  // S_DONE  | result presented, waiting for res_ready
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_s_q, alu_s_d;
  logic         alu_cin_q, alu_cin_d;
  logic [W-1:0] res_d_q, res_d_d;
  logic         res_cout_q, res_cout_d;
  logic         res_z_q, res_z_d;
  logic         res_valid_q, res_valid_d;
  logic [7:0]   op_count_q, op_count_d;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    alu_cin_d   = alu_cin_q;
    res_d_d     = res_d_q;
    res_cout_d  = res_cout_q;
    res_z_d     = res_z_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          // Chained ops read the result registers as they stand at the acceptance edge.
          alu_a_d   = op_use_acc ? res_d_q : op_a;
          alu_b_d   = op_b;
          alu_s_d   = op_sel;
          alu_cin_d = op_use_carry ? res_cout_q : op_cin;
          state_d   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        res_d_d     = alu_D;
        res_cout_d  = alu_C_out;
        res_z_d     = alu_z;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      alu_cin_q   <= 1'b0;
      res_d_q     <= '0;
      res_cout_q  <= 1'b0;
      res_z_q     <= 1'b0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      alu_cin_q   <= alu_cin_d;
      res_d_q     <= res_d_d;
      res_cout_q  <= res_cout_d;
      res_z_q     <= res_z_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign op_ready  = (state_q == S_IDLE);
  assign alu_A     = alu_a_q;
  assign alu_B     = alu_b_q;
  assign alu_S     = alu_s_q;
  assign alu_C_in  = alu_cin_q;
  assign res_valid = res_valid_q;
  assign res_d     = res_d_q;
  assign res_cout  = res_cout_q;
  assign res_z     = res_z_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder stub standing in for the ALU.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       op_valid, op_ready;
  logic [7:0] op_a, op_b;
  logic [3:0] op_sel;
  logic       op_cin, op_use_acc, op_use_carry;
  logic [7:0] alu_A, alu_B, alu_D;
  logic [3:0] alu_S;
  logic       alu_C_in, alu_C_out, alu_z;
  logic       res_valid, res_ready;
  logic [7:0] res_d;
  logic       res_cout, res_z;
  logic [7:0] op_count;

  int errors = 0;
  int checks = 0;

  alu_op_sequencer #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .op_cin(op_cin),
    .op_use_acc(op_use_acc), .op_use_carry(op_use_carry),
    .alu_A(alu_A), .alu_B(alu_B), .alu_S(alu_S), .alu_C_in(alu_C_in),
    .alu_D(alu_D), .alu_C_out(alu_C_out), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_d(res_d), .res_cout(res_cout), .res_z(res_z),
    .op_count(op_count)
  );

  // ALU stub: add with carry
  logic [8:0] alu_sum;
  assign alu_sum   = {1'b0, alu_A} + {1'b0, alu_B} + {8'd0, alu_C_in};
  assign alu_D     = alu_sum[7:0];
  assign alu_C_out = alu_sum[8];
  assign alu_z     = (alu_sum[7:0] == 8'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one op at a negedge and return 1 time unit after its acceptance edge.
  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                          input logic cin, input logic acc, input logic carry);
    int n;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!op_ready) begin
      errors++;
      $display("FAIL op_ready_timeout: got op_ready=%0b expected 1 within 10 cycles", op_ready);
    end
    op_a = a; op_b = b; op_sel = sel; op_cin = cin;
    op_use_acc = acc; op_use_carry = carry; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %0b expected 1", op_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid); end
    checks++; if ({alu_A, alu_B, alu_S, alu_C_in} !== 21'd0) begin errors++; $display("FAIL reset_alu: got A=%0d B=%0d S=%0d cin=%0b expected zeros", alu_A, alu_B, alu_S, alu_C_in); end
    checks++; if ({res_d, res_cout, res_z, op_count} !== 18'd0) begin errors++; $display("FAIL reset_res: got d=%0d c=%0b z=%0b cnt=%0d expected zeros", res_d, res_cout, res_z, op_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic basic_op(input string tag, input logic [7:0] exp_cnt);
    drive_op(8'd26, 8'd40, 4'b0000, 1'b1, 1'b0, 1'b0);
    checks++; if (alu_A !== 8'd26 || alu_B !== 8'd40) begin errors++; $display("FAIL %s_alu_ab: got A=%0d B=%0d expected 26 40", tag, alu_A, alu_B); end
    checks++; if (alu_S !== 4'd0 || alu_C_in !== 1'b1) begin errors++; $display("FAIL %s_alu_s_cin: got S=%0d cin=%0b expected 0 1", tag, alu_S, alu_C_in); end
    checks++; if (op_ready !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL %s_drive_flags: got ready=%0b valid=%0b expected 0 0", tag, op_ready, res_valid); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL %s_res_valid: got %0b expected 1", tag, res_valid); end
    checks++; if (res_d !== 8'd67 || res_cout !== 1'b0 || res_z !== 1'b0) begin errors++; $display("FAIL %s_result: got d=%0d c=%0b z=%0b expected 67 0 0", tag, res_d, res_cout, res_z); end
    @(posedge clk); #1;
    checks++; if (op_count !== exp_cnt || op_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL %s_handshake: got cnt=%0d ready=%0b valid=%0b expected %0d 1 0", tag, op_count, op_ready, res_valid, exp_cnt); end
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    basic_op("basic", 8'd1);
  endtask

  task automatic test_chain();
    drive_op(8'd200, 8'd100, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if (res_d !== 8'd44 || res_cout !== 1'b1) begin errors++; $display("FAIL chain1_result: got d=%0d c=%0b expected 44 1", res_d, res_cout); end
    @(posedge clk); #1;
    drive_op(8'd99, 8'd10, 4'b0000, 1'b0, 1'b1, 1'b1);
    checks++; if (alu_A !== 8'd44 || alu_C_in !== 1'b1 || alu_B !== 8'd10) begin errors++; $display("FAIL chain2_alu: got A=%0d B=%0d cin=%0b expected 44 10 1", alu_A, alu_B, alu_C_in); end
    @(posedge clk); #1;
    checks++; if (res_d !== 8'd55 || res_cout !== 1'b0) begin errors++; $display("FAIL chain2_result: got d=%0d c=%0b expected 55 0", res_d, res_cout); end
    @(posedge clk); #1;
    checks++; if (op_count !== 8'd3) begin errors++; $display("FAIL chain_count: got %0d expected 3", op_count); end
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    drive_op(8'd255, 8'd1, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op_valid = (i % 2 == 0);
      op_a = 8'd5; op_b = 8'd6; op_use_acc = 1'b0; op_use_carry = 1'b0;
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b1 || op_ready !== 1'b0) begin errors++; $display("FAIL bp_flags[%0d]: got valid=%0b ready=%0b expected 1 0", i, res_valid, op_ready); end
      checks++; if (res_d !== 8'd0 || res_cout !== 1'b1 || res_z !== 1'b1) begin errors++; $display("FAIL bp_result[%0d]: got d=%0d c=%0b z=%0b expected 0 1 1", i, res_d, res_cout, res_z); end
      checks++; if (alu_A !== 8'd255 || alu_B !== 8'd1) begin errors++; $display("FAIL bp_alu_hold[%0d]: got A=%0d B=%0d expected 255 1", i, alu_A, alu_B); end
    end
    @(negedge clk);
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (op_count !== 8'd4 || res_valid !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got cnt=%0d valid=%0b ready=%0b expected 4 0 1", op_count, res_valid, op_ready); end
    @(posedge clk); #1;
    checks++; if (op_count !== 8'd4 || op_ready !== 1'b1 || alu_A !== 8'd255) begin errors++; $display("FAIL bp_no_extra: got cnt=%0d ready=%0b A=%0d expected 4 1 255", op_count, op_ready, alu_A); end
  endtask

  task automatic test_reset_mid();
    drive_op(8'd7, 8'd8, 4'b0101, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got ready=%0b valid=%0b expected 1 0", op_ready, res_valid); end
    checks++; if ({alu_A, alu_B, alu_S, alu_C_in} !== 21'd0) begin errors++; $display("FAIL rstmid_alu: got A=%0d B=%0d S=%0d cin=%0b expected zeros", alu_A, alu_B, alu_S, alu_C_in); end
    checks++; if ({res_d, res_cout, res_z, op_count} !== 18'd0) begin errors++; $display("FAIL rstmid_res: got d=%0d c=%0b z=%0b cnt=%0d expected zeros", res_d, res_cout, res_z, op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || op_count !== 8'd0) begin errors++; $display("FAIL rstmid_discard: got valid=%0b cnt=%0d expected 0 0", res_valid, op_count); end
    basic_op("after_rst", 8'd1);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_cnt;
    logic [3:0] sel;
    logic [7:0] a, exp_d;
    exp_cnt = 8'd1;
    for (int i = 0; i < 256; i++) begin
      sel = 4'((i % 4) * 4);
      a = 8'(i);
      exp_d = 8'(i + 3);
      drive_op(a, 8'd3, sel, 1'b0, 1'b0, 1'b0);
      checks++; if (alu_S !== sel) begin errors++; $display("FAIL wrap_sel[%0d]: got %0d expected %0d", i, alu_S, sel); end
      @(posedge clk); #1;
      checks++; if (res_d !== exp_d) begin errors++; $display("FAIL wrap_res[%0d]: got %0d expected %0d", i, res_d, exp_d); end
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 8'd1;
      checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, op_count, exp_cnt); end
    end
    checks++; if (op_count !== 8'd1) begin errors++; $display("FAIL wrap_final: got %0d expected 1", op_count); end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int n_acc, n_res, exp_v;
    logic accept;
    n_acc = 0;
    n_res = 0;
    @(negedge clk);
    res_ready = 1'b1;
    op_valid = 1'b1;
    op_b = 8'd1; op_cin = 1'b0; op_use_acc = 1'b0; op_use_carry = 1'b0; op_sel = 4'd0;
    for (int c = 0; c < 12; c++) begin
      op_a = 8'(c + 10);
      accept = op_ready;
      checks++; if (accept !== (c % 3 == 0)) begin errors++; $display("FAIL b2b_ready[%0d]: got %0b expected %0b", c, accept, (c % 3 == 0)); end
      @(posedge clk); #1;
      if (accept) begin
        exp_q.push_back(c + 11);
        n_acc++;
      end
      if (res_valid) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++; if (int'(res_d) !== exp_v) begin errors++; $display("FAIL b2b_result[%0d]: got %0d expected %0d", c, res_d, exp_v); end
        n_res++;
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    checks++; if (n_acc !== 4 || n_res !== 4) begin errors++; $display("FAIL b2b_counts: got acc=%0d res=%0d expected 4 4", n_acc, n_res); end
    checks++; if (op_count !== 8'd5) begin errors++; $display("FAIL b2b_op_count: got %0d expected 5", op_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0; op_sel = '0; op_cin = 1'b0;
    op_use_acc = 1'b0; op_use_carry = 1'b0; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_chain();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
